datamemory_arbiter: RTL

Two-requester arbiter and access sequencer in front of the data memory. Port 0 is the CPU load/store unit; port 1 is the loader/debug port. The block grants one requester at a time in round-robin order and checks alignment and range. It then runs the memory's registered-read timing: one access cycle for loads, plus a commit cycle for byte/half stores, which need a read-modify-write. It returns a single-cycle response to the granted requester.

---
 rtl/datamemory_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/datamemory_arbiter.sv
// Round-robin arbiter and access sequencer in front of the data memory.
// Port 0 is the CPU load/store unit; port 1 is the loader/debug port.
module datamemory_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int MEMORY_SIZE   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic                     req0_we,
    input  logic [ADDRESS_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0]    req0_wdata,
    input  logic [2:0]               req0_ctrl,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic                     req1_we,
    input  logic [ADDRESS_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0]    req1_wdata,
    input  logic [2:0]               req1_ctrl,
    output logic                     resp0_valid,
    output logic                     resp1_valid,
    output logic [DATA_WIDTH-1:0]    resp_rdata,
    output logic                     resp_err,
    output logic                     busy,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]    mem_write_data,
    output logic [2:0]               mem_control,
    output logic                     mem_write_enable,
    input  logic [DATA_WIDTH-1:0]    mem_read_data
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t                   state_q;
    logic                     rr_last_q;
    logic                     port_q;
    logic                     we_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic [2:0]               ctrl_q;
    logic                     mem_we_q;
    logic                     resp0_q;
    logic                     resp1_q;
    logic                     err_q;
    logic [DATA_WIDTH-1:0]    rdata_q;

    logic                     grant0_d;
    logic                     grant1_d;
    logic                     accept_d;
    logic                     port_d;
    logic                     sel_we_d;
    logic [ADDRESS_WIDTH-1:0] sel_addr_d;
    logic [DATA_WIDTH-1:0]    sel_wdata_d;
    logic [2:0]               sel_ctrl_d;
    logic                     err_d;

    always_comb begin
        // rr_last_q names the port granted last, so a tie goes to the other one
        grant0_d    = req0_valid & (~req1_valid | rr_last_q);
        grant1_d    = req1_valid & (~req0_valid | ~rr_last_q);
        req0_ready  = (state_q == S_IDLE) & grant0_d;
        req1_ready  = (state_q == S_IDLE) & grant1_d;
        accept_d    = req0_ready | req1_ready;
        port_d      = req1_ready;
        sel_we_d    = port_d ? req1_we    : req0_we;
        sel_addr_d  = port_d ? req1_addr  : req0_addr;
        sel_wdata_d = port_d ? req1_wdata : req0_wdata;
        sel_ctrl_d  = port_d ? req1_ctrl  : req0_ctrl;
        err_d = (sel_ctrl_d == 3'b011) | (sel_ctrl_d == 3'b110) | (sel_ctrl_d == 3'b111)
              | (|(sel_addr_d >> (MEMORY_SIZE + 2)))
              | ((sel_ctrl_d[1:0] == 2'b01) & sel_addr_d[0])
              | ((sel_ctrl_d == 3'b010) & (|sel_addr_d[1:0]))
              | (sel_we_d & sel_ctrl_d[2]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rr_last_q <= 1'b1;
            port_q    <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ctrl_q    <= '0;
            mem_we_q  <= 1'b0;
            resp0_q   <= 1'b0;
            resp1_q   <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            mem_we_q <= 1'b0;
            resp0_q  <= 1'b0;
            resp1_q  <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            case (state_q)
                S_IDLE: begin
                    if (accept_d) begin
                        rr_last_q <= port_d;
                        port_q    <= port_d;
                        if (err_d) begin
                            // Rejected without touching memory; IDLE can accept next cycle
                            resp0_q <= ~port_d;
                            resp1_q <= port_d;
                            err_q   <= 1'b1;
                        end else begin
                            we_q     <= sel_we_d;
                            addr_q   <= sel_addr_d;
                            wdata_q  <= sel_wdata_d;
                            ctrl_q   <= sel_ctrl_d;
                            mem_we_q <= sel_we_d & (sel_ctrl_d == 3'b010);
                            state_q  <= S_ACCESS;
                        end
                    end
                end
                S_ACCESS: begin
                    if (we_q && (ctrl_q == 3'b010)) begin
                        resp0_q <= ~port_q;
                        resp1_q <= port_q;
                        state_q <= S_IDLE;
                    end else begin
                        // Sub-word stores commit here, after the old word was read
                        mem_we_q <= we_q;
                        state_q  <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    resp0_q <= ~port_q;
                    resp1_q <= port_q;
                    rdata_q <= we_q ? '0 : mem_read_data;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign resp0_valid      = resp0_q;
    assign resp1_valid      = resp1_q;
    assign resp_rdata       = rdata_q;
    assign resp_err         = err_q;
    assign busy             = (state_q != S_IDLE);
    assign mem_address      = addr_q;
    assign mem_write_data   = wdata_q;
    assign mem_control      = ctrl_q;
    assign mem_write_enable = mem_we_q;

endmodule
